// File: rtl/regfile_init_checker.sv
// Power-on init and self-check of the architectural register file: writes a keyed
// address pattern to every register, then reads them back two at a time and compares.
module regfile_init_checker #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 32,
  parameter logic [DATA_WIDTH-1:0] XOR_PAT    = 'hA5A50000,
  parameter bit                    ZERO_REG   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] RD1,
  input  logic [DATA_WIDTH-1:0] RD2,
  output logic [ADDR_WIDTH-1:0] A1,
  output logic [ADDR_WIDTH-1:0] A2,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic                  WE3,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  output logic [1:0]            DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(NUM_REGS - 2);
  localparam logic [ADDR_WIDTH-1:0] STEP1     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP2     = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] STEP3     = ADDR_WIDTH'(3);

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) ^ XOR_PAT;
  endfunction

  // Address 0 is still written, but a hardwired zero register reads back as 0.
  function automatic logic [DATA_WIDTH-1:0] expected(input logic [ADDR_WIDTH-1:0] a);
    if (ZERO_REG && (a == '0)) return '0;
    return pattern(a);
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
  logic                  we3_q, we3_d, busy_q, busy_d, done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  mm1, mm2;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    we3_d      = we3_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    mm1        = (RD1 != expected(a1_q));
    mm2        = (RD2 != expected(a2_q));
    case (state_q)
      S_IDLE: begin
        we3_d = 1'b0;
        if (START) begin
          state_d    = S_WRITE;
          cnt_d      = '0;
          a3_d       = '0;
          wd3_d      = pattern('0);
          we3_d      = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = '0;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_READ;
          we3_d   = 1'b0;
          cnt_d   = '0;
          a1_d    = '0;
          a2_d    = STEP1;
        end else begin
          cnt_d = cnt_q + STEP1;
          a3_d  = cnt_q + STEP1;
          wd3_d = pattern(cnt_q + STEP1);
        end
      end
      S_READ: begin
        // Only the first failing address is kept; port 1 has priority within a pair.
        if (!error_q) begin
          if (mm1) begin
            error_d    = 1'b1;
            err_addr_d = a1_q;
          end else if (mm2) begin
            error_d    = 1'b1;
            err_addr_d = a2_q;
          end
        end
        if (a1_q == LAST_PAIR) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a1_d    = '0;
          a2_d    = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + STEP2;
          a1_d  = cnt_q + STEP2;
          a2_d  = cnt_q + STEP3;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      wd3_q      <= '0;
      we3_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      we3_q      <= we3_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign A1        = a1_q;
  assign A2        = a2_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign WE3       = we3_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;
  assign ERR_ADDR  = err_addr_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_regfile_init_checker.sv
// Bench for regfile_init_checker: behavioural register file with fault injection on
// the read ports, a write-port monitor and a result scoreboard.
module tb_regfile_init_checker;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [31:0] RD1, RD2;
  logic [4:0]  A1, A2, A3, ERR_ADDR;
  logic [31:0] WD3;
  logic        WE3, BUSY, DONE, ERROR;
  logic [1:0]  DBG_STATE;

  logic [31:0] rf [32];
  logic [31:0] corrupt = '0;
  logic [5:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          we_cnt = 0;

  regfile_init_checker dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .RD1(RD1), .RD2(RD2),
    .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3), .BUSY(BUSY),
    .DONE(DONE), .ERROR(ERROR), .ERR_ADDR(ERR_ADDR), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // register file model: x0 hardwired, corrupted registers read as DEADBEEF
  always @(posedge CLK) if (WE3) rf[A3] <= WD3;
  always_comb begin
    RD1 = corrupt[A1] ? 32'hDEADBEEF : ((A1 == 5'd0) ? 32'd0 : rf[A1]);
    RD2 = corrupt[A2] ? 32'hDEADBEEF : ((A2 == 5'd0) ? 32'd0 : rf[A2]);
  end

  function automatic logic [31:0] pattern(input int a);
    return 32'(a) ^ 32'hA5A50000;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // write-port monitor: A3/WD3 must step through the pattern in order
  always @(negedge CLK) begin
    if (RST_N && WE3) begin
      check_val("wr_addr", 64'(A3), 64'(we_cnt));
      check_val("wr_data", 64'(WD3), 64'(pattern(we_cnt)));
      we_cnt++;
    end
  end

  // driver: one full run; ign_w/ign_r are edge indices after which START is pulsed
  task automatic run_seq(input logic [31:0] mask, input bit exp_err, input logic [4:0] exp_addr,
                         input int ign_w, input int ign_r);
    int         n;
    logic [5:0] exp;
    corrupt = mask;
    exp_q.push_back({exp_err, exp_addr});
    we_cnt = 0;
    @(negedge CLK); START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    check_val("start_edge", {61'd0, DONE, ERROR, BUSY}, 64'b001);
    n = 0;
    while (n < 200) begin
      @(negedge CLK); START = (n == ign_w) || (n == ign_r);
      @(posedge CLK); #1;
      n++;
      if (DONE) break;
    end
    START = 1'b0;
    check_val("latency", 64'(n), 64'd48);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check_val("result", {58'd0, ERROR, ERR_ADDR}, {58'd0, exp});
    end
    check_val("we_cycles", 64'(we_cnt), 64'd32);
    check_val("idle_end", {61'd0, BUSY, DBG_STATE}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {8'd0, A1, A2, A3, WD3, WE3, BUSY, DONE, ERROR, ERR_ADDR}, 64'd0);
  endtask

  initial begin
    int saved, k, r;
    for (int i = 0; i < 32; i++) rf[i] = 32'h12345678;

    #12; check_all_zero("por_reset");
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    check_val("idle_after_reset", {61'd0, WE3, DBG_STATE}, 64'd0);

    run_seq(32'd0, 1'b0, 5'd0, -1, -1);
    run_seq(32'd1 << 13, 1'b1, 5'd13, -1, -1);

    // asynchronous reset away from any edge, while DONE/ERROR are set
    @(posedge CLK); #2; RST_N = 1'b0; #1;
    check_all_zero("reset_mid_clock");
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    check_val("idle_release", {61'd0, WE3, DBG_STATE}, 64'd0);

    run_seq((32'd1 << 7) | (32'd1 << 20), 1'b1, 5'd7, -1, -1);
    run_seq((32'd1 << 6) | (32'd1 << 7), 1'b1, 5'd6, -1, -1);
    run_seq(32'd1 << 31, 1'b1, 5'd31, -1, -1);
    run_seq(32'd1, 1'b1, 5'd0, -1, -1);
    run_seq(32'd0, 1'b0, 5'd0, 5, 35);

    // reset while A3 = 10 abandons the run
    corrupt = '0;
    we_cnt = 0;
    @(negedge CLK); START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    k = 0;
    while (A3 != 5'd10 && k < 100) begin
      @(posedge CLK); #1; k++;
    end
    check_val("reach_a3_10", 64'(A3), 64'd10);
    #1; RST_N = 1'b0; #1;
    check_all_zero("reset_mid_run");
    saved = we_cnt;
    repeat (3) @(posedge CLK);
    #1;
    check_val("no_writes_in_reset", 64'(we_cnt), 64'(saved));
    @(negedge CLK); RST_N = 1'b1;
    run_seq(32'd0, 1'b0, 5'd0, -1, -1);

    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(1, 31);
      run_seq(32'd1 << r, 1'b1, 5'(r), -1, -1);
    end

    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
